// File: rtl/nanao_mix_pkg.sv
`default_nettype none
// ============================================================================
// Module      : nanao_mix_pkg
// Description : Shared constants and types for the video mixer sequencer:
//               register addresses, bank-mode encoding, register-file record
//               and default raster timing.
// Revision    : 1.0 - initial release
// ============================================================================
package nanao_mix_pkg;

  // Default raster timing (pixels per line / lines per frame)
  localparam int c_def_h_total  = 384;
  localparam int c_def_h_active = 256;
  localparam int c_def_v_total  = 264;
  localparam int c_def_v_active = 224;

  // CPU register addresses
  localparam logic [1:0] c_addr_mode    = 2'd0;
  localparam logic [1:0] c_addr_win_l   = 2'd1;
  localparam logic [1:0] c_addr_win_r   = 2'd2;
  localparam logic [1:0] c_addr_irq_clr = 2'd3;

  // Bank-select source for V1
  typedef enum logic [1:0] {
    BANK_ZERO  = 2'b00,
    BANK_ONE   = 2'b01,
    BANK_LINE  = 2'b10,
    BANK_FRAME = 2'b11
  } bankmode_e;

  // One copy of the programmable state (used for both shadow and active sets)
  typedef struct packed {
    bankmode_e   bankmode;
    logic        prien;
    logic        irqen;
    logic [7:0]  win_l;
    logic [7:0]  win_r;
  } mix_regs_t;

endpackage
`default_nettype wire

// File: rtl/nanao_mix_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : nanao_mix_seq_if
// Description : CPU register-write bus of the mixer sequencer.
//               CPU_WR  - write request, held until acknowledged
//               CPU_A   - register address (2 bits)
//               CPU_D   - write data (8 bits)
//               CPU_ACK - one-cycle write acknowledge
// Revision    : 1.0 - initial release
// ============================================================================
interface nanao_mix_seq_if;
  logic       CPU_WR;
  logic [1:0] CPU_A;
  logic [7:0] CPU_D;
  logic       CPU_ACK;

  modport master (output CPU_WR, output CPU_A, output CPU_D, input CPU_ACK);
  modport slave  (input CPU_WR, input CPU_A, input CPU_D, output CPU_ACK);
endinterface
`default_nettype wire

// File: rtl/nanao_mix_regs.sv
`default_nettype none
// ============================================================================
// Module      : nanao_mix_regs
// Description : CPU register file with write handshake, shadow registers,
//               frame-synchronous shadow->active transfer and the
//               vertical-blank interrupt flag.
// Ports       : CLK, RST    - clock, synchronous active-high reset
//               bus         - CPU write bus (slave side)
//               xfer        - high in the cycle whose edge starts VBLANK
//               act_next    - active register set as it will be after the edge
//               irq_vbl     - registered interrupt level
// Revision    : 1.0 - initial release
// ============================================================================
module nanao_mix_regs
  import nanao_mix_pkg::*;
(
  input  logic           CLK,
  input  logic           RST,
  nanao_mix_seq_if.slave bus,
  input  logic           xfer,
  output mix_regs_t      act_next,
  output logic           irq_vbl
);

  logic      ack_q, ack_d;
  logic      irq_q, irq_d;
  logic      accept;
  mix_regs_t shd_q, shd_d;
  mix_regs_t act_q, act_d;

  always_comb begin
    // The ACK cycle masks the still-held request so one hold = one write
    accept = bus.CPU_WR && !ack_q;
    ack_d  = accept;

    shd_d = shd_q;
    if (accept) begin
      case (bus.CPU_A)
        c_addr_mode: begin
          shd_d.bankmode = bankmode_e'(bus.CPU_D[1:0]);
          shd_d.prien    = bus.CPU_D[2];
          shd_d.irqen    = bus.CPU_D[3];
        end
        c_addr_win_l: shd_d.win_l = bus.CPU_D;
        c_addr_win_r: shd_d.win_r = bus.CPU_D;
        default: ;  // interrupt-clear address carries no data
      endcase
    end

    // Transfer takes the pre-edge shadow, so a write landing on the
    // transfer edge waits for the next frame
    act_d = xfer ? shd_q : act_q;

    // Set is applied last so it wins over a coincident clear
    irq_d = irq_q;
    if (accept && (bus.CPU_A == c_addr_irq_clr)) irq_d = 1'b0;
    if (xfer && act_d.irqen)                     irq_d = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      ack_q <= 1'b0;
      irq_q <= 1'b0;
      shd_q <= '0;
      act_q <= '0;
    end else begin
      ack_q <= ack_d;
      irq_q <= irq_d;
      shd_q <= shd_d;
      act_q <= act_d;
    end
  end

  assign bus.CPU_ACK = ack_q;
  assign act_next    = act_d;
  assign irq_vbl     = irq_q;

endmodule
`default_nettype wire

// File: rtl/nanao_mix_seq.sv
`default_nettype none
// ============================================================================
// Module      : nanao_mix_seq
// Description : Video mixer sequencer. Generates the half-pixel strobe H1,
//               pixel/line counters, blanking, bank select, layer-1 priority
//               window and the vertical-blank interrupt. All outputs are
//               registered and describe the counter values of the same cycle.
// Ports       : CLK, RST          - 2x pixel clock, synchronous active-high reset
//               bus               - CPU register write bus (slave side)
//               H1, H1E           - latch strobe, odd/even pixel half
//               V1, P1L           - bank select, layer-1 priority enable
//               HBLANK, VBLANK    - blanking
//               HCNT, VCNT        - pixel and line counters
//               IRQ_VBL           - vertical-blank interrupt level
// Revision    : 1.0 - initial release
// ============================================================================
module nanao_mix_seq
  import nanao_mix_pkg::*;
#(
  parameter int H_TOTAL  = c_def_h_total,
  parameter int H_ACTIVE = c_def_h_active,
  parameter int V_TOTAL  = c_def_v_total,
  parameter int V_ACTIVE = c_def_v_active
) (
  input  logic           CLK,
  input  logic           RST,
  nanao_mix_seq_if.slave bus,
  output logic           H1,
  output logic           H1E,
  output logic           V1,
  output logic           P1L,
  output logic           HBLANK,
  output logic           VBLANK,
  output logic [8:0]     HCNT,
  output logic [8:0]     VCNT,
  output logic           IRQ_VBL
);

  localparam logic [8:0] c_h_last = 9'(H_TOTAL - 1);
  localparam logic [8:0] c_h_act  = 9'(H_ACTIVE);
  localparam logic [8:0] c_v_last = 9'(V_TOTAL - 1);
  localparam logic [8:0] c_v_act  = 9'(V_ACTIVE);

  logic       h1_q, h1_d;
  logic [8:0] hcnt_q, hcnt_d;
  logic [8:0] vcnt_q, vcnt_d;
  logic       frame_q, frame_d;
  logic       h1e_q, h1e_d;
  logic       v1_q, v1_d;
  logic       p1l_q, p1l_d;
  logic       hblank_q, hblank_d;
  logic       vblank_q, vblank_d;
  logic       line_wrap;
  logic       xfer;
  logic [8:0] win_lo, win_hi;
  mix_regs_t  act_next;

  // Counters: one pixel per two CLK cycles, advancing while H1 is high
  always_comb begin
    h1_d      = ~h1_q;
    hcnt_d    = hcnt_q;
    vcnt_d    = vcnt_q;
    frame_d   = frame_q;
    line_wrap = h1_q && (hcnt_q == c_h_last);
    if (h1_q) begin
      hcnt_d = line_wrap ? '0 : hcnt_q + 9'd1;
    end
    if (line_wrap) begin
      if (vcnt_q == c_v_last) begin
        vcnt_d  = '0;
        frame_d = ~frame_q;
      end else begin
        vcnt_d = vcnt_q + 9'd1;
      end
    end
    // The edge that moves VCNT onto the first blank line, HCNT = 0
    xfer = line_wrap && (vcnt_d == c_v_act);
  end

  nanao_mix_regs u_regs (
    .CLK      (CLK),
    .RST      (RST),
    .bus      (bus),
    .xfer     (xfer),
    .act_next (act_next),
    .irq_vbl  (IRQ_VBL)
  );

  // Output decode works on next-state values so the registered outputs
  // line up with the registered counters
  always_comb begin
    win_lo   = {act_next.win_l, 1'b0};
    win_hi   = {act_next.win_r, 1'b0};
    h1e_d    = hcnt_d[0];
    hblank_d = (hcnt_d >= c_h_act);
    vblank_d = (vcnt_d >= c_v_act);
    // An empty or inverted window naturally never matches
    p1l_d    = act_next.prien && !hblank_d && !vblank_d &&
               (hcnt_d >= win_lo) && (hcnt_d < win_hi);
    v1_d     = 1'b0;
    case (act_next.bankmode)
      BANK_ZERO:  v1_d = 1'b0;
      BANK_ONE:   v1_d = 1'b1;
      BANK_LINE:  v1_d = vcnt_d[0];
      BANK_FRAME: v1_d = frame_d;
      default:    v1_d = 1'b0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      h1_q     <= 1'b0;
      hcnt_q   <= '0;
      vcnt_q   <= '0;
      frame_q  <= 1'b0;
      h1e_q    <= 1'b0;
      v1_q     <= 1'b0;
      p1l_q    <= 1'b0;
      hblank_q <= 1'b0;
      vblank_q <= 1'b0;
    end else begin
      h1_q     <= h1_d;
      hcnt_q   <= hcnt_d;
      vcnt_q   <= vcnt_d;
      frame_q  <= frame_d;
      h1e_q    <= h1e_d;
      v1_q     <= v1_d;
      p1l_q    <= p1l_d;
      hblank_q <= hblank_d;
      vblank_q <= vblank_d;
    end
  end

  assign H1     = h1_q;
  assign H1E    = h1e_q;
  assign V1     = v1_q;
  assign P1L    = p1l_q;
  assign HBLANK = hblank_q;
  assign VBLANK = vblank_q;
  assign HCNT   = hcnt_q;
  assign VCNT   = vcnt_q;

endmodule
`default_nettype wire

// File: tb/tb_nanao_mix_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_nanao_mix_seq
// Description : Self-checking bench for nanao_mix_seq. A behavioural model
//               derives every expected output from the CLK count since reset
//               and queues one record per edge; each scenario task pops and
//               compares one record per cycle, plus targeted spot checks.
//               Raster timing is scaled down so multi-frame scenarios stay short.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nanao_mix_seq;

  localparam int HT = 96;
  localparam int HA = 80;
  localparam int VT = 24;
  localparam int VA = 16;
  localparam int LINE_CYC  = 2 * HT;
  localparam int FRAME_CYC = 2 * HT * VT;

  typedef struct packed {
    logic [1:0] a;
    logic [7:0] d;
    logic       hold;
  } req_t;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       H1, H1E, V1, P1L, HBLANK, VBLANK, IRQ_VBL;
  logic [8:0] HCNT, VCNT;
  logic [25:0] obs;

  nanao_mix_seq_if bus ();

  nanao_mix_seq #(
    .H_TOTAL (HT), .H_ACTIVE (HA), .V_TOTAL (VT), .V_ACTIVE (VA)
  ) dut (
    .CLK (CLK), .RST (RST), .bus (bus),
    .H1 (H1), .H1E (H1E), .V1 (V1), .P1L (P1L),
    .HBLANK (HBLANK), .VBLANK (VBLANK),
    .HCNT (HCNT), .VCNT (VCNT), .IRQ_VBL (IRQ_VBL)
  );

  always #5 CLK = ~CLK;

  assign obs = {H1, H1E, V1, P1L, HBLANK, VBLANK, IRQ_VBL, bus.CPU_ACK, HCNT, VCNT};

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- reference model / scoreboard producer ----------------
  int        m_n, m_fp, m_hc, m_vc, m_frame;
  bit        m_ack, m_irq, m_acc, m_xf;
  bit [7:0]  s_mode, s_wl, s_wr, a_mode, a_wl, a_wr;
  bit        e_v1, e_p1l, e_hb, e_vb;
  logic [25:0] sb_q[$];

  always @(posedge CLK) begin
    if (RST) begin
      m_n = 0; m_ack = 0; m_irq = 0;
      s_mode = 0; s_wl = 0; s_wr = 0; a_mode = 0; a_wl = 0; a_wr = 0;
    end else begin
      m_acc = bus.CPU_WR && !m_ack;
      m_n   = m_n + 1;
      m_xf  = (m_n % 2 == 0) && (((m_n / 2) % (HT * VT)) == VA * HT);
      if (m_xf) begin a_mode = s_mode; a_wl = s_wl; a_wr = s_wr; end
      if (m_acc && bus.CPU_A == 2'd3) m_irq = 0;
      if (m_xf && a_mode[3]) m_irq = 1;
      if (m_acc) begin
        case (bus.CPU_A)
          2'd0: s_mode = bus.CPU_D;
          2'd1: s_wl   = bus.CPU_D;
          2'd2: s_wr   = bus.CPU_D;
          default: ;
        endcase
      end
      m_ack = m_acc;
    end
    m_fp    = (m_n / 2) % (HT * VT);
    m_hc    = m_fp % HT;
    m_vc    = m_fp / HT;
    m_frame = ((m_n / 2) / (HT * VT)) % 2;
    e_hb    = (m_hc >= HA);
    e_vb    = (m_vc >= VA);
    case (a_mode[1:0])
      2'd0: e_v1 = 1'b0;
      2'd1: e_v1 = 1'b1;
      2'd2: e_v1 = m_vc[0];
      default: e_v1 = m_frame[0];
    endcase
    e_p1l = a_mode[2] && !e_hb && !e_vb &&
            (m_hc >= 2 * int'(a_wl)) && (m_hc < 2 * int'(a_wr));
    sb_q.push_back({m_n[0], m_hc[0], e_v1, e_p1l, e_hb, e_vb, m_irq, m_ack,
                    9'(m_hc), 9'(m_vc)});
  end

  // ---------------- CPU write driver ----------------
  req_t wq[$];
  req_t cur;
  bit   busy, drop_next;

  initial begin
    busy = 0; drop_next = 0;
    bus.CPU_WR = 1'b0; bus.CPU_A = 2'd0; bus.CPU_D = 8'd0;
    forever begin
      @(posedge CLK); #2;
      if (RST) begin
        busy = 0; drop_next = 0; bus.CPU_WR = 1'b0;
      end else if (busy) begin
        if (drop_next) begin
          bus.CPU_WR = 1'b0; busy = 0; drop_next = 0;
        end else if (bus.CPU_ACK) begin
          if (cur.hold) drop_next = 1;
          else begin bus.CPU_WR = 1'b0; busy = 0; end
        end
      end
      if (!RST && !busy && wq.size() > 0) begin
        cur = wq.pop_front();
        bus.CPU_A = cur.a; bus.CPU_D = cur.d; bus.CPU_WR = 1'b1; busy = 1;
      end
    end
  end

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [25:0] e;
    RST = 1'b1;
    for (int c = 0; c < LINE_CYC + 16; c++) begin
      @(posedge CLK); #1;
      if (sb_q.size() == 0) begin
        n_tests++; n_fail++; $display("FAIL reset_vec: no expected entry queued");
      end else begin
        e = sb_q.pop_front(); n_tests++;
        if (obs !== e) begin
          n_fail++;
          $display("FAIL reset_vec n=%0d: got %h (HCNT=%0d VCNT=%0d) want %h (HCNT=%0d VCNT=%0d)",
                   m_n, obs, obs[17:9], obs[8:0], e, e[17:9], e[8:0]);
        end
      end
      if (c == 3) RST = 1'b0;
      if (c == 4) begin
        n_tests++;
        if (H1 !== 1'b1 || HCNT !== 9'd0) begin
          n_fail++; $display("FAIL reset_first_clk: got H1=%b HCNT=%0d want H1=1 HCNT=0", H1, HCNT);
        end
      end
      if (c == 5) begin
        n_tests++;
        if (H1 !== 1'b0 || HCNT !== 9'd1) begin
          n_fail++; $display("FAIL reset_hcnt1: got H1=%b HCNT=%0d want H1=0 HCNT=1", H1, HCNT);
        end
      end
      if (!RST && m_n == 2 * HA) begin
        n_tests++;
        if (HBLANK !== 1'b1 || HCNT !== 9'(HA)) begin
          n_fail++; $display("FAIL hblank_start: got HBLANK=%b HCNT=%0d want 1 and %0d", HBLANK, HCNT, HA);
        end
      end
      if (!RST && m_n == 2 * HT) begin
        n_tests++;
        if (HCNT !== 9'd0 || VCNT !== 9'd1) begin
          n_fail++; $display("FAIL line_wrap: got HCNT=%0d VCNT=%0d want 0 and 1", HCNT, VCNT);
        end
      end
    end
  endtask

  task automatic test_bank_line();
    logic [25:0] e;
    int ph = 0, acks = 0, win = 0;
    bit done = 0;
    for (int c = 0; c < 3 * FRAME_CYC && !done; c++) begin
      @(posedge CLK); #1;
      if (sb_q.size() == 0) begin
        n_tests++; n_fail++; $display("FAIL bank_line_vec: no expected entry queued");
      end else begin
        e = sb_q.pop_front(); n_tests++;
        if (obs !== e) begin
          n_fail++;
          $display("FAIL bank_line_vec n=%0d: got %h (HCNT=%0d VCNT=%0d) want %h (HCNT=%0d VCNT=%0d)",
                   m_n, obs, obs[17:9], obs[8:0], e, e[17:9], e[8:0]);
        end
      end
      if (ph == 0 && m_vc == 10 && m_hc == 5 && m_n[0]) begin
        wq.push_back(req_t'{a: 2'd0, d: 8'h02, hold: 1'b1});
        ph = 1;
      end else if (ph == 1) begin
        if (bus.CPU_ACK === 1'b1) acks++;
        win++;
        if (win == 10) begin
          n_tests++;
          if (acks !== 1) begin n_fail++; $display("FAIL held_wr_acks: got %0d acks want 1", acks); end
          ph = 2;
        end
      end else if (ph == 2 && m_vc == VA - 1 && m_hc == 3) begin
        n_tests++;
        if (V1 !== 1'b0) begin n_fail++; $display("FAIL v1_before_xfer: got V1=%b want 0", V1); end
        ph = 3;
      end else if (ph == 3 && m_vc == VA + 1 && m_hc == 3) begin
        n_tests++;
        if (V1 !== 1'b1) begin n_fail++; $display("FAIL v1_line_mode: got V1=%b want 1", V1); end
        done = 1;
      end
    end
    if (!done) begin n_tests++; n_fail++; $display("FAIL bank_line_timeout: got phase %0d want done", ph); end
  endtask

  task automatic test_window();
    logic [25:0] e;
    int ph = 0, cnt = 0;
    bit done = 0;
    wq.push_back(req_t'{a: 2'd1, d: 8'h10, hold: 1'b0});
    wq.push_back(req_t'{a: 2'd2, d: 8'h20, hold: 1'b0});
    wq.push_back(req_t'{a: 2'd0, d: 8'h04, hold: 1'b0});
    for (int c = 0; c < 4 * FRAME_CYC && !done; c++) begin
      @(posedge CLK); #1;
      if (sb_q.size() == 0) begin
        n_tests++; n_fail++; $display("FAIL window_vec: no expected entry queued");
      end else begin
        e = sb_q.pop_front(); n_tests++;
        if (obs !== e) begin
          n_fail++;
          $display("FAIL window_vec n=%0d: got %h (HCNT=%0d VCNT=%0d) want %h (HCNT=%0d VCNT=%0d)",
                   m_n, obs, obs[17:9], obs[8:0], e, e[17:9], e[8:0]);
        end
      end
      if ((ph == 0 || ph == 2) && m_vc == VA && m_hc == 0 && !m_n[0]) begin
        ph = ph + 1; cnt = 0;
      end else if (ph == 1 || ph == 3) begin
        if (m_vc == 1 && P1L === 1'b1) cnt++;
        if (m_vc == 2) begin
          n_tests++;
          if (ph == 1) begin
            if (cnt !== 64) begin n_fail++; $display("FAIL window_width: got %0d P1L cycles want 64", cnt); end
            wq.push_back(req_t'{a: 2'd2, d: 8'h10, hold: 1'b0});
            ph = 2;
          end else begin
            if (cnt !== 0) begin n_fail++; $display("FAIL window_empty: got %0d P1L cycles want 0", cnt); end
            done = 1;
          end
        end
      end
    end
    if (!done) begin n_tests++; n_fail++; $display("FAIL window_timeout: got phase %0d want done", ph); end
  endtask

  task automatic test_irq();
    logic [25:0] e;
    int ph = 0;
    bit done = 0;
    wq.push_back(req_t'{a: 2'd0, d: 8'h08, hold: 1'b0});
    for (int c = 0; c < 3 * FRAME_CYC && !done; c++) begin
      @(posedge CLK); #1;
      if (sb_q.size() == 0) begin
        n_tests++; n_fail++; $display("FAIL irq_vec: no expected entry queued");
      end else begin
        e = sb_q.pop_front(); n_tests++;
        if (obs !== e) begin
          n_fail++;
          $display("FAIL irq_vec n=%0d: got %h (HCNT=%0d VCNT=%0d) want %h (HCNT=%0d VCNT=%0d)",
                   m_n, obs, obs[17:9], obs[8:0], e, e[17:9], e[8:0]);
        end
      end
      if (ph == 0 && m_vc == VA && m_hc == 0 && !m_n[0]) begin
        n_tests++;
        if (IRQ_VBL !== 1'b1) begin n_fail++; $display("FAIL irq_rise: got IRQ_VBL=%b want 1", IRQ_VBL); end
        wq.push_back(req_t'{a: 2'd3, d: 8'h00, hold: 1'b0});
        ph = 1;
      end else if (ph == 1 && m_vc == VA && m_hc == 10) begin
        n_tests++;
        if (IRQ_VBL !== 1'b0) begin n_fail++; $display("FAIL irq_clear: got IRQ_VBL=%b want 0", IRQ_VBL); end
        ph = 2;
      end else if (ph == 2 && m_fp == VA * HT - 1 && m_n[0]) begin
        // lands the clear on the very edge that sets the flag
        wq.push_back(req_t'{a: 2'd3, d: 8'h00, hold: 1'b0});
        ph = 3;
      end else if (ph == 3 && m_vc == VA && m_hc == 3) begin
        n_tests++;
        if (IRQ_VBL !== 1'b1) begin n_fail++; $display("FAIL irq_set_vs_clear: got IRQ_VBL=%b want 1", IRQ_VBL); end
        wq.push_back(req_t'{a: 2'd3, d: 8'h00, hold: 1'b0});
        ph = 4;
      end else if (ph == 4 && m_vc == VA && m_hc == 20) begin
        done = 1;
      end
    end
    if (!done) begin n_tests++; n_fail++; $display("FAIL irq_timeout: got phase %0d want done", ph); end
  endtask

  task automatic test_bank_frame();
    logic [25:0] e;
    int ph = 0, caps = 0;
    bit done = 0;
    wq.push_back(req_t'{a: 2'd0, d: 8'h03, hold: 1'b0});
    for (int c = 0; c < 7 * FRAME_CYC && !done; c++) begin
      @(posedge CLK); #1;
      if (sb_q.size() == 0) begin
        n_tests++; n_fail++; $display("FAIL bank_frame_vec: no expected entry queued");
      end else begin
        e = sb_q.pop_front(); n_tests++;
        if (obs !== e) begin
          n_fail++;
          $display("FAIL bank_frame_vec n=%0d: got %h (HCNT=%0d VCNT=%0d) want %h (HCNT=%0d VCNT=%0d)",
                   m_n, obs, obs[17:9], obs[8:0], e, e[17:9], e[8:0]);
        end
      end
      if (ph == 0 && m_vc == VA && m_hc == 0 && !m_n[0]) begin
        ph = 1;
      end else if (ph == 1 && m_vc == 1 && m_hc == 0 && !m_n[0]) begin
        n_tests++;
        if (V1 !== m_frame[0]) begin
          n_fail++; $display("FAIL v1_frame_toggle: got V1=%b want %b", V1, m_frame[0]);
        end
        caps++;
        if (caps == 3) ph = 2;
      end else if (ph == 2 && m_vc == 12 && m_hc == 0 && !m_n[0]) begin
        RST = 1'b1;
        ph = 3;
      end else if (ph == 3) begin
        n_tests++;
        if (obs !== 26'd0) begin n_fail++; $display("FAIL midframe_reset: got %h want 0000000", obs); end
        RST = 1'b0;
        ph = 4;
      end else if (ph == 4) begin
        n_tests++;
        if (H1 !== 1'b1 || HCNT !== 9'd0 || VCNT !== 9'd0) begin
          n_fail++; $display("FAIL restart: got H1=%b HCNT=%0d VCNT=%0d want 1 0 0", H1, HCNT, VCNT);
        end
        done = 1;
      end
    end
    if (!done) begin n_tests++; n_fail++; $display("FAIL bank_frame_timeout: got phase %0d want done", ph); end
  endtask

  initial begin
    test_reset();
    test_bank_line();
    test_window();
    test_irq();
    test_bank_frame();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
